alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 148 ++++++++++++++
 tb/tb_alu_mc.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL,
// valid/ready handshake on both sides with registered result and flags.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q, neg_q, carry_q, ovf_q, err_q;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     res_d;
  logic                 carry_d, ovf_d, err_d;
  logic                 accept;

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff = a - b;

  // Single-cycle datapath; MUL result comes from the iterative accumulator.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff;
        carry_d = (a >= b);
        ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_NOR: res_d = ~(a | b);
      OP_MUL: res_d = '0;
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: res_d = a << b[SHW-1:0];
      OP_SRL: res_d = a >> b[SHW-1:0];
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (opcode == OP_MUL) begin
        state_q  <= BUSY;
        cnt_q    <= CW'(WIDTH);
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
      end else begin
        state_q  <= DONE;
        result_q <= res_d;
        zero_q   <= (res_d == '0);
        neg_q    <= res_d[WIDTH-1];
        carry_q  <= carry_d;
        ovf_q    <= ovf_d;
        err_q    <= err_d;
      end
    end else begin
      case (state_q)
        BUSY: begin
          // WIDTH add steps, then one extra cycle to publish the product.
          if (cnt_q == '0) begin
            state_q  <= DONE;
            result_q <= acc_q[WIDTH-1:0];
            zero_q   <= (acc_q[WIDTH-1:0] == '0);
            neg_q    <= acc_q[WIDTH-1];
            carry_q  <= |acc_q[2*WIDTH-1:WIDTH];
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
          end else begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=8: flags, MUL latency,
// back-to-back throughput, output hold under backpressure, reset abort.
module tb_alu_mc;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready;
  logic [3:0] opcode;
  logic [7:0] a, b, result;
  logic       zero, neg, carry, ovf, err;
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .neg(neg),
    .carry(carry), .ovf(ovf), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r,
                         input logic z, input logic n, input logic c,
                         input logic o, input logic e);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_res"}, result, r);
    chk({tag, "_z"}, zero, z);
    chk({tag, "_n"}, neg, n);
    chk({tag, "_c"}, carry, c);
    chk({tag, "_o"}, ovf, o);
    chk({tag, "_e"}, err, e);
  endtask

  // Present one request for one edge; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] ta,
                      input logic [7:0] tb_, input logic tc);
    chk("send_rdy", in_ready, 1);
    opcode = op; a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    chk("back_idle", out_valid, 0);
  endtask

  task automatic op1(input string tag, input logic [3:0] op, input logic [7:0] ta,
                     input logic [7:0] tb_, input logic tc, input logic [7:0] r,
                     input logic z, input logic n, input logic c,
                     input logic o, input logic e);
    send(op, ta, tb_, tc);
    chk_out(tag, r, z, n, c, o, e);
    idle_step();
  endtask

  task automatic mul_run(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] r, input logic c);
    int lat = 0;
    int rdy_bad = 0;
    send(4'b1000, ta, tb_, 1'b0);
    while (out_valid !== 1'b1 && lat < 30) begin
      if (in_ready !== 1'b0) rdy_bad++;
      // a request offered mid-BUSY must be ignored
      if (lat == 2) begin opcode = 4'b0000; a = 8'h01; b = 8'h01; in_valid = 1'b1; end
      if (lat == 5) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_busy_rdy"}, rdy_bad, 0);
    chk_out(tag, r, (r == 8'h00), r[7], c, 1'b0, 1'b0);
    idle_step();
  endtask

  initial begin
    int hits;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {zero, neg, carry, ovf, err}, 0);
    chk("rst_rdy", in_ready, 0);
    rst_n = 1'b1; #1;
    chk("rel_rdy", in_ready, 1);

    //   tag       op       a      b      cin  res    z n c o e
    op1("add_ovf", 4'b0000, 8'h7F, 8'h01, 0, 8'h80, 0,1,0,1,0);
    op1("add_cin", 4'b0000, 8'hFF, 8'h01, 1, 8'h01, 0,0,1,0,0);
    op1("sub_eq",  4'b0010, 8'h05, 8'h05, 0, 8'h00, 1,0,1,0,0);
    op1("sub_ovf", 4'b0010, 8'h80, 8'h01, 0, 8'h7F, 0,0,1,1,0);
    op1("sub_brw", 4'b0010, 8'h01, 8'h02, 0, 8'hFF, 0,1,0,0,0);
    op1("slt",     4'b1010, 8'hFF, 8'h01, 0, 8'h01, 0,0,0,0,0);
    op1("sll",     4'b1100, 8'h81, 8'hF9, 0, 8'h02, 0,0,0,0,0);
    op1("sll0",    4'b1100, 8'hA5, 8'hF8, 0, 8'hA5, 0,1,0,0,0);
    op1("srl",     4'b1101, 8'h80, 8'h0F, 0, 8'h01, 0,0,0,0,0);
    op1("and",     4'b0100, 8'hF0, 8'h3C, 0, 8'h30, 0,0,0,0,0);
    op1("or",      4'b0101, 8'h80, 8'h01, 0, 8'h81, 0,1,0,0,0);
    op1("nor",     4'b0111, 8'h0F, 8'hF0, 0, 8'h00, 1,0,0,0,0);
    op1("bad_f",   4'b1111, 8'h12, 8'h34, 0, 8'h00, 1,0,0,0,1);
    op1("bad_1",   4'b0001, 8'hFF, 8'hFF, 1, 8'h00, 1,0,0,0,1);

    mul_run("mul_a", 8'h10, 8'h11, 8'h10, 1'b1);
    mul_run("mul_b", 8'h0F, 8'h0F, 8'hE1, 1'b0);

    // back-to-back XOR, then backpressure hold
    opcode = 4'b0110; a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    chk_out("xor0", 8'hFF, 0,1,0,0,0);
    chk("xor0_rdy", in_ready, 1);
    a = 8'h0F; b = 8'h0F;
    @(posedge clk); #1;
    chk_out("xor1", 8'h00, 1,0,0,0,0);
    a = 8'h80; b = 8'h01;
    @(posedge clk); #1;
    chk_out("xor2", 8'h81, 0,1,0,0,0);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk_out("hold", 8'h81, 0,1,0,0,0);
      chk("hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    idle_step();

    // reset in the 4th BUSY cycle aborts the MUL
    send(4'b1000, 8'h10, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_vld", out_valid, 0);
    chk("abort_res", result, 0);
    chk("abort_flags", {zero, neg, carry, ovf, err}, 0);
    chk("abort_rdy", in_ready, 0);
    rst_n = 1'b1; #1;
    hits = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) hits++;
    end
    chk("abort_novld", hits, 0);
    op1("add_post", 4'b0000, 8'h01, 8'h01, 0, 8'h02, 0,0,0,0,0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
